// File: rtl/neuron_learn_layer_seq.sv
// Time-multiplexed M x N fully-connected learning layer: one shared MAC runs the forward pass,
// then optionally a delta-rule weight update with back-propagated targets. Optional: NEURON_ACT_TRACK_EN.
module neuron_learn_layer_seq #(
  parameter int N = 16,
  parameter int M = 53,
  parameter int DW = 8,
  parameter int WW = 16,
  parameter int LR_SHIFT = 4,
  parameter logic [WW-1:0] INIT_W = 16'h0400
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   learn,
  input  logic [N*DW-1:0]        in,
  input  logic [M*DW-1:0]        expected_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [M*DW-1:0]        out,
  output logic [N*DW-1:0]        expected_in,
  input  logic [$clog2(M)-1:0]   rd_row,
  input  logic [$clog2(N)-1:0]   rd_col,
  output logic [WW-1:0]          rd_data,
  output logic [M*DW-1:0]        act_max,
  output logic [M*DW-1:0]        act_min
);

  localparam int RW = $clog2(M);
  localparam int CW = $clog2(N);
  localparam int FRAC = 32'd12;
  localparam int MW1 = DW + WW + 1;
  localparam int AW = DW + WW + CW + 2;
  localparam int EW = DW + WW + RW + 2;
  localparam int XW = DW + WW + CW + RW + 4;
  localparam int PW = 2 * DW + 2;
  localparam int UW = WW + 2 * DW + 4;
  localparam int UPD_SH = 32'd4 + LR_SHIFT;
  localparam int ERR_SH = FRAC + RW;

  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, BWD = 2'd2, HOLD = 2'd3} state_t;

  function automatic logic [DW-1:0] sat_act(input logic signed [XW-1:0] v);
    logic [DW-1:0] r;
    if (v[XW-1]) r = {DW{1'b0}};
    else if (|v[XW-2:DW]) r = {DW{1'b1}};
    else r = v[DW-1:0];
    return r;
  endfunction

  function automatic logic signed [WW-1:0] sat_w(input logic signed [UW-1:0] v);
    logic signed [WW-1:0] r;
    if (v[UW-1] && !(&v[UW-2:WW-1])) r = {1'b1, {(WW-1){1'b0}}};
    else if (!v[UW-1] && (|v[UW-2:WW-1])) r = {1'b0, {(WW-1){1'b1}}};
    else r = v[WW-1:0];
    return r;
  endfunction

  state_t state_r, state_next_s;
  logic in_ready_r, out_valid_r, learn_r;
  logic [RW-1:0] j_r, j_step_s;
  logic [CW-1:0] i_r, i_step_s;
  logic last_i_s, last_s, accept_s;
  logic [DW-1:0] in_r [N];
  logic [DW-1:0] exp_r [M];
  logic [DW-1:0] out_r [M];
  logic [DW-1:0] expin_r [N];
  logic signed [WW-1:0] w_r [M][N];
  logic signed [AW-1:0] acc_r, acc_sum_s;
  logic signed [EW-1:0] eacc_r [N];
  logic signed [EW-1:0] eacc_fin_s [N];
  logic signed [WW-1:0] rd_data_r, w_cur_s, w_new_s;
  logic signed [DW:0] in_cur_s, err_s;
  logic signed [MW1-1:0] prod_s, eprod_s;
  logic signed [PW-1:0] upd_s;
  logic signed [UW-1:0] w_sum_s;
  logic [DW-1:0] out_new_s;

  assign accept_s = in_valid && in_ready_r;
  assign last_i_s = (i_r == CW'(N - 1));
  assign last_s = last_i_s && (j_r == RW'(M - 1));
  assign i_step_s = last_i_s ? {CW{1'b0}} : i_r + CW'(1'b1);
  assign j_step_s = !last_i_s ? j_r : (last_s ? {RW{1'b0}} : j_r + RW'(1'b1));

  // Shared MAC, delta-rule and error back-propagation arithmetic for the current (j,i).
  always_comb begin
    w_cur_s = w_r[j_r][i_r];
    in_cur_s = {1'b0, in_r[i_r]};
    err_s = $signed({1'b0, exp_r[j_r]}) - $signed({1'b0, out_r[j_r]});
    prod_s = MW1'(in_cur_s) * MW1'(w_cur_s);
    acc_sum_s = acc_r + AW'(prod_s);
    out_new_s = sat_act(XW'(acc_sum_s >>> FRAC));
    upd_s = PW'(err_s) * PW'(in_cur_s);
    w_sum_s = UW'(w_cur_s) + UW'(upd_s >>> UPD_SH);
    w_new_s = sat_w(w_sum_s);
    eprod_s = MW1'(err_s) * MW1'(w_cur_s);
    for (int k = 0; k < N; k++) begin
      if (CW'(k) == i_r) eacc_fin_s[k] = eacc_r[k] + EW'(eprod_s);
      else eacc_fin_s[k] = eacc_r[k];
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: if (accept_s) state_next_s = FWD; else state_next_s = IDLE;
      FWD:  if (last_s) state_next_s = learn_r ? BWD : HOLD; else state_next_s = FWD;
      BWD:  if (last_s) state_next_s = HOLD; else state_next_s = BWD;
      HOLD: if (out_valid_r && out_ready) state_next_s = IDLE; else state_next_s = HOLD;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs; out_valid rises one cycle into HOLD.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      in_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      in_ready_r <= (state_next_s == IDLE);
      out_valid_r <= (state_r == HOLD) && (state_next_s == HOLD);
    end
  end

  // Datapath: latch on accept, MAC walk in FWD, read-modify-write walk in BWD, weight read port.
  always_ff @(posedge clock) begin
    if (reset) begin
      learn_r <= 1'b0;
      j_r <= {RW{1'b0}};
      i_r <= {CW{1'b0}};
      acc_r <= {AW{1'b0}};
      rd_data_r <= {WW{1'b0}};
      for (int k = 0; k < N; k++) begin
        in_r[k] <= {DW{1'b0}};
        expin_r[k] <= {DW{1'b0}};
        eacc_r[k] <= {EW{1'b0}};
      end
      for (int j = 0; j < M; j++) begin
        exp_r[j] <= {DW{1'b0}};
        out_r[j] <= {DW{1'b0}};
        for (int k = 0; k < N; k++) w_r[j][k] <= INIT_W;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            learn_r <= learn;
            j_r <= {RW{1'b0}};
            i_r <= {CW{1'b0}};
            acc_r <= {AW{1'b0}};
            for (int k = 0; k < N; k++) begin
              in_r[k] <= in[k*DW +: DW];
              eacc_r[k] <= {EW{1'b0}};
            end
            for (int j = 0; j < M; j++) exp_r[j] <= expected_out[j*DW +: DW];
          end
        end
        FWD: begin
          if (last_i_s) begin
            out_r[j_r] <= out_new_s;
            acc_r <= {AW{1'b0}};
          end else begin
            acc_r <= acc_sum_s;
          end
          if (last_s && !learn_r) begin
            for (int k = 0; k < N; k++) expin_r[k] <= in_r[k];
          end
          i_r <= i_step_s;
          j_r <= j_step_s;
        end
        BWD: begin
          w_r[j_r][i_r] <= w_new_s;
          eacc_r[i_r] <= eacc_fin_s[i_r];
          if (last_s) begin
            for (int k = 0; k < N; k++)
              expin_r[k] <= sat_act($signed(XW'(in_r[k])) + XW'(eacc_fin_s[k] >>> ERR_SH));
          end
          i_r <= i_step_s;
          j_r <= j_step_s;
        end
        default: begin
        end
      endcase
      if ((32'(rd_row) < M) && (32'(rd_col) < N)) rd_data_r <= w_r[rd_row][rd_col];
      else rd_data_r <= {WW{1'b0}};
    end
  end

  assign in_ready = in_ready_r;
  assign out_valid = out_valid_r;
  assign rd_data = rd_data_r;

  for (genvar g = 0; g < M; g++) begin : g_out
    assign out[g*DW +: DW] = out_r[g];
  end
  for (genvar g = 0; g < N; g++) begin : g_expin
    assign expected_in[g*DW +: DW] = expin_r[g];
  end

`ifdef NEURON_ACT_TRACK_EN
  logic [DW-1:0] act_max_r [M];
  logic [DW-1:0] act_min_r [M];

  // Per-neuron output extremes, updated whenever a forward output is written.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < M; j++) begin
        act_max_r[j] <= {DW{1'b0}};
        act_min_r[j] <= {DW{1'b1}};
      end
    end else if ((state_r == FWD) && last_i_s) begin
      if (out_new_s > act_max_r[j_r]) act_max_r[j_r] <= out_new_s;
      if (out_new_s < act_min_r[j_r]) act_min_r[j_r] <= out_new_s;
    end
  end

  for (genvar g = 0; g < M; g++) begin : g_act
    assign act_max[g*DW +: DW] = act_max_r[g];
    assign act_min[g*DW +: DW] = act_min_r[g];
  end
`else
  assign act_max = {(M*DW){1'b1}};
  assign act_min = {(M*DW){1'b0}};
`endif

endmodule
